// File: rtl/pixel_ctrl.sv
`default_nettype none
// ============================================================================
// pixel_ctrl : frame sequencer for a 4-pixel array (erase/expose/convert/read)
// Revision   : 1.0
// ============================================================================
module pixel_ctrl #(
    parameter int ERASE_CYCLES = 5,
    parameter int CNT_W        = 8
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic [7:0]       expose_time,
    output logic             erase,
    output logic             expose,
    output logic             convert,
    output logic [3:0]       read,
    output logic [CNT_W-1:0] cnt_out,
    output logic             cnt_oe,
    input  logic [CNT_W-1:0] data_in,
    output logic [CNT_W-1:0] pixel_data,
    output logic [1:0]       pixel_idx,
    output logic             pixel_valid,
    output logic             busy,
    output logic             frame_done
);

    localparam logic [2:0] c_idle    = 3'd0;
    localparam logic [2:0] c_erase   = 3'd1;
    localparam logic [2:0] c_expose  = 3'd2;
    localparam logic [2:0] c_convert = 3'd3;
    localparam logic [2:0] c_read    = 3'd4;

    localparam logic [7:0]       c_erase_last = 8'(ERASE_CYCLES - 1);
    localparam logic [7:0]       c_read_last  = 8'd7;
    localparam logic [CNT_W-1:0] c_cnt_max    = '1;
    localparam logic [CNT_W-1:0] c_cnt_one    = {{(CNT_W-1){1'b0}}, 1'b1};

    logic [2:0]       r_state;
    logic [7:0]       r_phase;
    logic [7:0]       r_exp;
    logic [CNT_W-1:0] r_cnt;

    logic             r_erase;
    logic             r_expose;
    logic             r_convert;
    logic [3:0]       r_read;
    logic             r_cnt_oe;
    logic [CNT_W-1:0] r_pixel_data;
    logic [1:0]       r_pixel_idx;
    logic             r_pixel_valid;
    logic             r_busy;
    logic             r_frame_done;

    logic [2:0]       w_state_nxt;
    logic [7:0]       w_phase_nxt;
    logic [7:0]       w_exp_nxt;
    logic [CNT_W-1:0] w_cnt_nxt;
    logic             w_capture;

    // r_phase is a shared in-state cycle counter; in READ its bits [2:1]
    // select the pixel and bit 0 marks the second (capture) cycle.
    always_comb begin
        w_state_nxt = r_state;
        w_phase_nxt = r_phase;
        w_exp_nxt   = r_exp;
        w_cnt_nxt   = r_cnt;
        w_capture   = 1'b0;
        case (r_state)
            c_idle: begin
                if (start) begin
                    w_state_nxt = c_erase;
                    w_phase_nxt = 8'd0;
                    w_exp_nxt   = (expose_time == 8'd0) ? 8'd1 : expose_time;
                end
            end
            c_erase: begin
                if (r_phase == c_erase_last) begin
                    w_state_nxt = c_expose;
                    w_phase_nxt = 8'd0;
                end else begin
                    w_phase_nxt = r_phase + 8'd1;
                end
            end
            c_expose: begin
                if (r_phase == r_exp - 8'd1) begin
                    w_state_nxt = c_convert;
                    w_cnt_nxt   = '0;
                end else begin
                    w_phase_nxt = r_phase + 8'd1;
                end
            end
            c_convert: begin
                // Counter stops at full scale and holds it after leaving.
                if (r_cnt == c_cnt_max) begin
                    w_state_nxt = c_read;
                    w_phase_nxt = 8'd0;
                end else begin
                    w_cnt_nxt = r_cnt + c_cnt_one;
                end
            end
            c_read: begin
                w_capture = r_phase[0];
                if (r_phase == c_read_last) begin
                    w_state_nxt = c_idle;
                end else begin
                    w_phase_nxt = r_phase + 8'd1;
                end
            end
            default: begin
                w_state_nxt = c_idle;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state       <= c_idle;
            r_phase       <= 8'd0;
            r_exp         <= 8'd0;
            r_cnt         <= '0;
            r_erase       <= 1'b0;
            r_expose      <= 1'b0;
            r_convert     <= 1'b0;
            r_read        <= 4'd0;
            r_cnt_oe      <= 1'b0;
            r_pixel_data  <= '0;
            r_pixel_idx   <= 2'd0;
            r_pixel_valid <= 1'b0;
            r_busy        <= 1'b0;
            r_frame_done  <= 1'b0;
        end else begin
            r_state       <= w_state_nxt;
            r_phase       <= w_phase_nxt;
            r_exp         <= w_exp_nxt;
            r_cnt         <= w_cnt_nxt;
            // Strobes are decoded from the next state so they line up with it.
            r_erase       <= (w_state_nxt == c_erase);
            r_expose      <= (w_state_nxt == c_expose);
            r_convert     <= (w_state_nxt == c_convert);
            r_cnt_oe      <= (w_state_nxt == c_convert);
            r_read        <= (w_state_nxt == c_read) ? (4'b0001 << w_phase_nxt[2:1]) : 4'd0;
            r_busy        <= (w_state_nxt != c_idle);
            r_pixel_valid <= w_capture;
            r_frame_done  <= w_capture && (r_phase == c_read_last);
            if (w_capture) begin
                r_pixel_data <= data_in;
                r_pixel_idx  <= r_phase[2:1];
            end
        end
    end

    assign erase       = r_erase;
    assign expose      = r_expose;
    assign convert     = r_convert;
    assign read        = r_read;
    assign cnt_out     = r_cnt;
    assign cnt_oe      = r_cnt_oe;
    assign pixel_data  = r_pixel_data;
    assign pixel_idx   = r_pixel_idx;
    assign pixel_valid = r_pixel_valid;
    assign busy        = r_busy;
    assign frame_done  = r_frame_done;

endmodule
`default_nettype wire

// File: tb/tb_pixel_ctrl.sv
`default_nettype none
// ============================================================================
// tb_pixel_ctrl : directed, table-driven checks of the pixel_ctrl frame timing
// Revision      : 1.0
// ============================================================================
module tb_pixel_ctrl;

    logic       clk;
    logic       reset;
    logic       start;
    logic [7:0] expose_time;
    logic       erase;
    logic       expose;
    logic       convert;
    logic [3:0] read;
    logic [7:0] cnt_out;
    logic       cnt_oe;
    logic [7:0] data_in;
    logic [7:0] pixel_data;
    logic [1:0] pixel_idx;
    logic       pixel_valid;
    logic       busy;
    logic       frame_done;

    int n_checks = 0;
    int n_errors = 0;

    pixel_ctrl #(.ERASE_CYCLES(5), .CNT_W(8)) dut (
        .clk        (clk),
        .reset      (reset),
        .start      (start),
        .expose_time(expose_time),
        .erase      (erase),
        .expose     (expose),
        .convert    (convert),
        .read       (read),
        .cnt_out    (cnt_out),
        .cnt_oe     (cnt_oe),
        .data_in    (data_in),
        .pixel_data (pixel_data),
        .pixel_idx  (pixel_idx),
        .pixel_valid(pixel_valid),
        .busy       (busy),
        .frame_done (frame_done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // {erase,expose,convert,read,cnt_out,cnt_oe,pixel_data,pixel_idx,pixel_valid,busy,frame_done}
    logic [28:0] w_obs;
    assign w_obs = {erase, expose, convert, read, cnt_out, cnt_oe,
                    pixel_data, pixel_idx, pixel_valid, busy, frame_done};

    typedef struct {
        int         cyc;
        logic [28:0] exp_out;
    } vec_t;

    vec_t vt[$];

    function automatic vec_t mk(int c, logic e, logic x, logic cv, logic [3:0] rd,
                                logic [7:0] co, logic oe, logic [7:0] pd, logic [1:0] pi,
                                logic pv, logic bsy, logic fd);
        vec_t v;
        v.cyc     = c;
        v.exp_out = {e, x, cv, rd, co, oe, pd, pi, pv, bsy, fd};
        return v;
    endfunction

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", nm, act, exp);
        end
    endtask

    task automatic do_reset();
        for (int i = 0; i < 4; i++) begin
            @(posedge clk);
            #1;
            reset       = (i < 3);
            start       = (i < 3) ? 1'($urandom) : 1'b0;
            expose_time = 8'($urandom);
            data_in     = 8'($urandom);
            @(negedge clk);
            if (i > 0) chk($sformatf("reset_outputs_%0d", i), {3'd0, w_obs}, 32'd0);
        end
    endtask

    function automatic logic [7:0] read_data(int cyc);
        if (cyc >= 272 && cyc <= 279) return 8'h11 * 8'((cyc - 272) / 2 + 1);
        return 8'hA5;
    endfunction

    // One expose_time=10 frame checked against the table; start also pulsed mid-EXPOSE.
    task automatic run_frame_table(input string tag);
        int n_erase = 0, n_expose = 0, n_conv = 0, n_read = 0;
        int n_pv = 0, n_fd = 0, n_busy = 0, n_excl = 0;
        for (int cyc = 0; cyc <= 281; cyc++) begin
            @(posedge clk);
            #1;
            reset       = 1'b0;
            start       = (cyc == 0) || (cyc == 8);
            expose_time = 8'd10;
            data_in     = read_data(cyc);
            @(negedge clk);
            foreach (vt[i]) begin
                if (vt[i].cyc == cyc)
                    chk($sformatf("%s_vec_c%0d", tag, cyc), {3'd0, w_obs}, {3'd0, vt[i].exp_out});
            end
            n_erase  += int'(erase);
            n_expose += int'(expose);
            n_conv   += int'(convert && cnt_oe);
            n_read   += int'(read != 4'd0);
            n_pv     += int'(pixel_valid);
            n_fd     += int'(frame_done);
            n_busy   += int'(busy);
            if (int'(erase) + int'(expose) + int'(convert) + int'(read != 4'd0) > 1) n_excl++;
        end
        chk({tag, "_erase_cycles"},  n_erase,  5);
        chk({tag, "_expose_cycles"}, n_expose, 10);
        chk({tag, "_convert_cycles"}, n_conv,  256);
        chk({tag, "_read_cycles"},   n_read,   8);
        chk({tag, "_valid_count"},   n_pv,     4);
        chk({tag, "_done_count"},    n_fd,     1);
        chk({tag, "_busy_cycles"},   n_busy,   279);
        chk({tag, "_exclusive"},     n_excl,   0);
    endtask

    initial begin
        reset       = 1'b1;
        start       = 1'b0;
        expose_time = 8'd0;
        data_in     = 8'd0;

        //          cyc  er ex cv rd     cnt    oe pd     pi pv bsy fd
        vt.push_back(mk(0,   0, 0, 0, 4'h0, 8'd0,   0, 8'h00, 0, 0, 0, 0));
        vt.push_back(mk(1,   1, 0, 0, 4'h0, 8'd0,   0, 8'h00, 0, 0, 1, 0));
        vt.push_back(mk(5,   1, 0, 0, 4'h0, 8'd0,   0, 8'h00, 0, 0, 1, 0));
        vt.push_back(mk(6,   0, 1, 0, 4'h0, 8'd0,   0, 8'h00, 0, 0, 1, 0));
        vt.push_back(mk(15,  0, 1, 0, 4'h0, 8'd0,   0, 8'h00, 0, 0, 1, 0));
        vt.push_back(mk(16,  0, 0, 1, 4'h0, 8'd0,   1, 8'h00, 0, 0, 1, 0));
        vt.push_back(mk(116, 0, 0, 1, 4'h0, 8'd100, 1, 8'h00, 0, 0, 1, 0));
        vt.push_back(mk(271, 0, 0, 1, 4'h0, 8'd255, 1, 8'h00, 0, 0, 1, 0));
        vt.push_back(mk(272, 0, 0, 0, 4'h1, 8'd255, 0, 8'h00, 0, 0, 1, 0));
        vt.push_back(mk(273, 0, 0, 0, 4'h1, 8'd255, 0, 8'h00, 0, 0, 1, 0));
        vt.push_back(mk(274, 0, 0, 0, 4'h2, 8'd255, 0, 8'h11, 0, 1, 1, 0));
        vt.push_back(mk(275, 0, 0, 0, 4'h2, 8'd255, 0, 8'h11, 0, 0, 1, 0));
        vt.push_back(mk(276, 0, 0, 0, 4'h4, 8'd255, 0, 8'h22, 1, 1, 1, 0));
        vt.push_back(mk(278, 0, 0, 0, 4'h8, 8'd255, 0, 8'h33, 2, 1, 1, 0));
        vt.push_back(mk(279, 0, 0, 0, 4'h8, 8'd255, 0, 8'h33, 2, 0, 1, 0));
        vt.push_back(mk(280, 0, 0, 0, 4'h0, 8'd255, 0, 8'h44, 3, 1, 0, 1));
        vt.push_back(mk(281, 0, 0, 0, 4'h0, 8'd255, 0, 8'h44, 3, 0, 0, 0));

        do_reset();
        run_frame_table("frameA");

        // start held high: next frame accepted in the first IDLE cycle
        do_reset();
        for (int cyc = 0; cyc <= 282; cyc++) begin
            @(posedge clk);
            #1;
            start       = 1'b1;
            expose_time = 8'd10;
            data_in     = read_data(cyc);
            @(negedge clk);
            if (cyc == 280) chk("held_c280", {erase, busy, pixel_valid, frame_done, pixel_idx}, 6'b001111);
            if (cyc == 281) chk("held_c281", {erase, busy}, 2'b11);
        end

        // expose_time = 0 is stretched to a single expose cycle
        do_reset();
        begin
            int n_exp = 0;
            for (int cyc = 0; cyc <= 272; cyc++) begin
                @(posedge clk);
                #1;
                start       = (cyc == 0);
                expose_time = 8'd0;
                data_in     = 8'h5A;
                @(negedge clk);
                n_exp += int'(expose);
                if (cyc == 6)   chk("exp0_c6_expose", {erase, expose, convert}, 3'b010);
                if (cyc == 7)   chk("exp0_c7_convert", {convert, cnt_oe, cnt_out}, {2'b11, 8'd0});
                if (cyc == 271) chk("exp0_c271_done", {frame_done, pixel_valid, busy}, 3'b110);
            end
            chk("exp0_expose_cycles", n_exp, 1);
        end

        // reset in CONVERT at cnt_out=100, with start asserted in the same cycle
        do_reset();
        for (int cyc = 0; cyc <= 116; cyc++) begin
            @(posedge clk);
            #1;
            start       = (cyc == 0) || (cyc == 116);
            reset       = (cyc == 116);
            expose_time = 8'd10;
            @(negedge clk);
            if (cyc == 116) chk("abort_c116_cnt", {convert, cnt_out}, {1'b1, 8'd100});
        end
        begin
            int n_strobe = 0;
            for (int cyc = 117; cyc <= 122; cyc++) begin
                @(posedge clk);
                #1;
                reset = 1'b0;
                start = 1'b0;
                @(negedge clk);
                if (cyc == 117) chk("abort_c117_zero", {3'd0, w_obs}, 32'd0);
                n_strobe += int'(pixel_valid) + int'(frame_done) + int'(busy);
            end
            chk("abort_no_strobes", n_strobe, 0);
        end
        run_frame_table("frameD");

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/pixel_ctrl.md
PIXEL_CTRL -- requirements
Module: pixel_ctrl

Interface
REQ-001 SHALL have parameter ERASE_CYCLES, default 5: number of cycles erase is held high per frame.
REQ-002 SHALL have parameter CNT_W, default 8: width of the conversion counter and data path.
REQ-003 SHALL have port clk  input  1  sole clock; all state updates on rising edge.
REQ-004 SHALL have port reset  input  1  synchronous, active-high reset.
REQ-005 SHALL have port start  input  1  frame request, sampled only in IDLE.
REQ-006 SHALL have port expose_time  input  8  exposure length in cycles, latched when start is accepted.
REQ-007 SHALL have port erase  output  1  pixel erase strobe to the pixel array.
REQ-008 SHALL have port expose  output  1  pixel expose strobe to the pixel array.
REQ-009 SHALL have port convert  output  1  ramp/compare phase enable for the analog ramp generator.
REQ-010 SHALL have port read  output  4  one-hot pixel read selects; bits 0..3 map to pixels 1..4.
REQ-011 SHALL have port cnt_out  output  CNT_W  conversion counter value for the shared DATA bus.
REQ-012 SHALL have port cnt_oe  output  1  high when cnt_out is to drive the DATA bus.
REQ-013 SHALL have port data_in  input  CNT_W  DATA bus value as driven by the selected pixel.
REQ-014 SHALL have port pixel_data  output  CNT_W  captured pixel code.
REQ-015 SHALL have port pixel_idx  output  2  index (0..3) of the pixel in pixel_data.
REQ-016 SHALL have port pixel_valid  output  1  single-cycle strobe: pixel_data/pixel_idx valid.
REQ-017 SHALL have port busy  output  1  high whenever state is not IDLE.
REQ-018 SHALL have port frame_done  output  1  single-cycle strobe at end of frame.

Function
REQ-019 SHALL implement states IDLE, ERASE, EXPOSE, CONVERT, READ; all outputs are registered.
REQ-020 SHALL, in IDLE with start=1, latch expose_time (0 replaced by 1) and enter ERASE next cycle.
REQ-021 SHALL assert erase for exactly ERASE_CYCLES cycles in ERASE, then enter EXPOSE.
REQ-022 SHALL assert expose for exactly the latched exposure count in EXPOSE, then enter CONVERT.
REQ-023 SHALL, in CONVERT, assert convert and cnt_oe, with cnt_out = 0 on the first cycle, +1 per cycle, up to 2^CNT_W-1.
REQ-024 SHALL leave CONVERT after the cycle with cnt_out = 2^CNT_W-1 (256 cycles at default), with no wrap to 0 while in CONVERT.
REQ-025 SHALL, in READ, assert read[i] for 2 cycles each for i = 0,1,2,3 in order, with no gap between pixels (8 cycles total).
REQ-026 SHALL sample data_in into pixel_data on the edge ending the 2nd read cycle of pixel i, and set pixel_idx = i.
REQ-027 SHALL assert pixel_valid for one cycle after each sample.
REQ-028 SHALL return to IDLE after the 8th read cycle.
REQ-029 SHALL assert frame_done together with the pixel_valid for idx 3 (the first IDLE cycle).
REQ-030 SHALL keep erase, expose, convert and read mutually exclusive; at most one of them is nonzero in any cycle.
REQ-031 SHALL hold cnt_oe low outside CONVERT; cnt_out holds its last value outside CONVERT and is 0 after reset.
REQ-032 SHALL ignore start while busy; if start is held high, the next frame is accepted in the first IDLE cycle.
REQ-033 SHALL leave pixel_data unchanged except on capture edges.

Reset
REQ-034 SHALL, when reset=1 at a clock edge, go to IDLE regardless of state.
REQ-035 SHALL, on that reset, set erase, expose, convert, read, cnt_out, cnt_oe, pixel_data, pixel_idx, pixel_valid, busy and frame_done to 0, and clear the latched exposure count.
REQ-036 SHALL give reset priority over start in the same cycle; a frame in progress is abandoned with no pixel_valid or frame_done.

Verification
REQ-037 SHALL cover: reset held 3 cycles with random inputs -> every output 0, busy 0.
REQ-038 SHALL cover: start at cycle 0, expose_time=10 -> erase cycles 1-5; expose 6-15; convert/cnt_oe 16-271 with cnt_out 0..255; read 272-279; busy 1-279.
REQ-039 SHALL cover: data_in = 0x11, 0x22, 0x33, 0x44 during read windows 0..3 -> pixel_valid at cycles 274, 276, 278, 280 carrying (0x11,0), (0x22,1), (0x33,2), (0x44,3); frame_done at 280.
REQ-040 SHALL cover: expose_time=0 -> expose high for exactly 1 cycle.
REQ-041 SHALL cover: start pulsed during EXPOSE -> ignored; start held high -> second frame's erase begins cycle 281.
REQ-042 SHALL cover: reset at cnt_out=100 in CONVERT -> next cycle IDLE, all outputs 0, no pixel_valid; start afterwards -> normal frame.
